// File: rtl/trigger_interval_timer.sv
// Trigger-to-trigger interval timer: counts sample ticks between accepted triggers into a FWFT FIFO.
// Define TRIGGER_INTERVAL_HOLDOFF_EN to reject retriggers arriving fewer than HOLDOFF ticks apart.
module trigger_interval_timer #(
    parameter int COUNT_WIDTH = 16,
    parameter int FIFO_DEPTH  = 8,
    parameter int HOLDOFF     = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         axiiv,
    input  logic                         triggered,
    output logic                         axiov,
    output logic [COUNT_WIDTH-1:0]       axiod,
    input  logic                         axior,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
    output logic                         overflow
);
    // state    | meaning
    // IDLE     | no reference trigger seen since reset
    // COUNTING | measuring ticks since the last accepted trigger

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

    typedef enum logic {IDLE, COUNTING} state_t;

    state_t                   state, state_next;
    logic [COUNT_WIDTH-1:0]   count, count_next;
    logic                     accept, push, pop, full, do_push;
    logic [COUNT_WIDTH-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]            wr_ptr, rd_ptr;

`ifdef TRIGGER_INTERVAL_HOLDOFF_EN
    assign accept = triggered && (count >= COUNT_WIDTH'(HOLDOFF));
`else
    assign accept = triggered;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    // A tick coincident with an accepted trigger belongs to the new interval.
    always_comb begin
        state_next = state;
        count_next = count;
        push       = 1'b0;
        case (state)
            IDLE: begin
                if (triggered) begin
                    state_next = COUNTING;
                    count_next = axiiv ? COUNT_WIDTH'(1) : '0;
                end
            end
            COUNTING: begin
                if (accept) begin
                    push       = 1'b1;
                    count_next = axiiv ? COUNT_WIDTH'(1) : '0;
                end else if (axiiv && (count != COUNT_MAX)) begin
                    count_next = count + COUNT_WIDTH'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign axiov   = (fifo_count != '0);
    assign axiod   = mem[rd_ptr];
    assign full    = (fifo_count == (AW+1)'(FIFO_DEPTH));
    assign pop     = axiov && axior;
    assign do_push = push && (!full || pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= count;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && full && !pop) begin
                overflow <= 1'b1;
            end
            case ({do_push, pop})
                2'b10:   fifo_count <= fifo_count + (AW+1)'(1);
                2'b01:   fifo_count <= fifo_count - (AW+1)'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end
endmodule

// File: tb/tb_trigger_interval_timer.sv
// Directed bench for trigger_interval_timer; holdoff cases follow TRIGGER_INTERVAL_HOLDOFF_EN.
module tb_trigger_interval_timer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        axiiv = 1'b0;
    logic        triggered = 1'b0;
    logic        axior = 1'b0;
    logic        axiov;
    logic [15:0] axiod;
    logic [3:0]  fifo_count;
    logic        overflow;

    logic        triggered8 = 1'b0;
    logic        axiov8;
    logic [7:0]  axiod8;
    logic [3:0]  fifo_count8;
    logic        overflow8;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    trigger_interval_timer dut (
        .clk(clk), .rst(rst), .axiiv(axiiv), .triggered(triggered),
        .axiov(axiov), .axiod(axiod), .axior(axior),
        .fifo_count(fifo_count), .overflow(overflow)
    );

    trigger_interval_timer #(.COUNT_WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .axiiv(axiiv), .triggered(triggered8),
        .axiov(axiov8), .axiod(axiod8), .axior(1'b1),
        .fifo_count(fifo_count8), .overflow(overflow8)
    );

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        triggered = 1'b0;
        triggered8 = 1'b0;
        cyc(1);
        rst = 1'b0;
    endtask

    task automatic pulse();
        triggered = 1'b1;
        cyc(1);
        triggered = 1'b0;
    endtask

    initial begin
        cyc(2);
        chk("reset_axiov", 32'(axiov), 0);
        chk("reset_count", 32'(fifo_count), 0);
        chk("reset_overflow", 32'(overflow), 0);
        chk("reset_axiod", 32'(axiod), 0);
        rst = 1'b0;

        // Interval of 100 ticks
        axiiv = 1'b1;
        axior = 1'b1;
        pulse();
        chk("first_trig_no_push", 32'(axiov), 0);
        cyc(99);
        pulse();
        chk("i100_axiov", 32'(axiov), 1);
        chk("i100_axiod", 32'(axiod), 100);
        chk("i100_count", 32'(fifo_count), 1);
        cyc(1);
        chk("i100_popped", 32'(axiov), 0);

`ifdef TRIGGER_INTERVAL_HOLDOFF_EN
        do_reset();
        pulse();
        cyc(1);
        pulse();
        chk("holdoff_reject", 32'(fifo_count), 0);
        cyc(7);
        pulse();
        chk("holdoff_axiov", 32'(axiov), 1);
        chk("holdoff_axiod", 32'(axiod), 10);
`else
        do_reset();
        pulse();
        cyc(1);
        pulse();
        chk("nohold_axiov", 32'(axiov), 1);
        chk("nohold_axiod", 32'(axiod), 2);
        do_reset();
        axiiv = 1'b0;
        triggered = 1'b1;
        cyc(2);
        triggered = 1'b0;
        chk("zero_axiov", 32'(axiov), 1);
        chk("zero_axiod", 32'(axiod), 0);
        axiiv = 1'b1;
`endif

        // Saturation on the 8-bit instance
        do_reset();
        triggered8 = 1'b1;
        cyc(1);
        triggered8 = 1'b0;
        cyc(299);
        triggered8 = 1'b1;
        cyc(1);
        triggered8 = 1'b0;
        chk("sat_axiov", 32'(axiov8), 1);
        chk("sat_axiod", 32'(axiod8), 255);

        // Overflow: 10 intervals 5..14 with no readout
        do_reset();
        axior = 1'b0;
        pulse();
        for (int len = 5; len <= 14; len++) begin
            cyc(len - 1);
            pulse();
        end
        chk("ovf_count", 32'(fifo_count), 8);
        chk("ovf_flag", 32'(overflow), 1);
        axior = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("drain_axiov", 32'(axiov), 1);
            chk("drain_axiod", 32'(axiod), 32'(5 + i));
            cyc(1);
        end
        chk("drain_empty", 32'(axiov), 0);
        chk("drain_count", 32'(fifo_count), 0);
        chk("ovf_sticky", 32'(overflow), 1);

        // Asynchronous reset mid-operation
        do_reset();
        axior = 1'b0;
        pulse();
        for (int k = 0; k < 3; k++) begin
            cyc(4);
            pulse();
        end
        chk("pre_rst_count", 32'(fifo_count), 3);
        cyc(2);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_axiov", 32'(axiov), 0);
        chk("arst_count", 32'(fifo_count), 0);
        chk("arst_overflow", 32'(overflow), 0);
        cyc(1);
        rst = 1'b0;
        axior = 1'b1;
        pulse();
        chk("post_rst_first", 32'(fifo_count), 0);
        cyc(19);
        pulse();
        chk("post_rst_axiov", 32'(axiov), 1);
        chk("post_rst_axiod", 32'(axiod), 20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
